// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential packed-BCD adder.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned BCD_MAX  = 9;
    localparam int unsigned BCD_CORR = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    function automatic logic bcd_digit_invalid(input bcd_digit_t d);
        return d > 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_seq_adder_ctrl_if.sv
// Operand/result handshake bundle between producer, adder controller and consumer.
interface bcd_seq_adder_ctrl_if #(
    parameter int unsigned NDIG = 8
);
    localparam int unsigned W = 4 * NDIG;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;
    logic         err;
    logic         busy;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, err, busy
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, err, busy
    );

endinterface

// File: rtl/bcd2_slice.sv
// Combinational two-digit BCD adder slice, digit 0 carry ripples into digit 1.
module bcd2_slice
    import bcd_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [4:0] t0;
    logic [4:0] t1;
    logic       c0;

    always_comb begin
        t0      = 5'(a[3:0]) + 5'(b[3:0]) + 5'(cin);
        c0      = t0 > 5'(BCD_MAX);
        s[3:0]  = c0 ? 4'(t0 + 5'(BCD_CORR)) : t0[3:0];
        t1      = 5'(a[7:4]) + 5'(b[7:4]) + 5'(c0);
        cout    = t1 > 5'(BCD_MAX);
        s[7:4]  = cout ? 4'(t1 + 5'(BCD_CORR)) : t1[3:0];
    end

endmodule

// File: rtl/bcd_seq_adder_ctrl.sv
// Multi-digit packed-BCD adder reusing one 2-digit slice, LS digit pair first.
module bcd_seq_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_seq_adder_ctrl_if.slave  bus
);

    localparam int unsigned W     = 4 * NDIG;
    localparam int unsigned NPAIR = NDIG / 2;
    localparam int unsigned IDXW  = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    ctrl_state_t     state;
    ctrl_state_t     state_d;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    s_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic            cout_q;
    logic            err_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            in_ready_d;
    logic            out_valid_d;
    logic            busy_d;

    logic [7:0]      pair_a;
    logic [7:0]      pair_b;
    logic [7:0]      pair_s;
    logic            pair_cout;
    logic            accept_c;
    logic            last_c;
    logic            err_c;

    assign accept_c = (state == IDLE) && bus.in_valid;
    assign last_c   = (idx_q == IDXW'(NPAIR - 1));
    assign pair_a   = a_q[8*idx_q +: 8];
    assign pair_b   = b_q[8*idx_q +: 8];

    bcd2_slice u_slice (
        .a    (pair_a),
        .b    (pair_b),
        .cin  (carry_q),
        .s    (pair_s),
        .cout (pair_cout)
    );

    // Any out-of-range nibble on either incoming operand
    always_comb begin
        err_c = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            err_c = err_c | bcd_digit_invalid(bus.A[4*i +: 4])
                          | bcd_digit_invalid(bus.B[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last_c)       state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the upcoming state
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            if (accept_c) begin
                a_q     <= bus.A;
                b_q     <= bus.B;
                carry_q <= bus.Cin;
                idx_q   <= '0;
                s_q     <= '0;
                cout_q  <= 1'b0;
                err_q   <= err_c;
            end else if (state == RUN) begin
                s_q[8*idx_q +: 8] <= pair_s;
                carry_q           <= pair_cout;
                idx_q             <= IDXW'(idx_q + 1'b1);
                if (last_c) begin
                    cout_q <= pair_cout;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_seq_adder_ctrl.sv
// Directed self-checking bench for the sequential BCD adder controller (NDIG=8).
module tb_bcd_seq_adder_ctrl;

    localparam int unsigned NDIG = 8;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    bcd_seq_adder_ctrl_if #(.NDIG(NDIG)) bus ();

    bcd_seq_adder_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge, then scramble inputs and wait for out_valid
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c, output int lat);
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = c;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.A        = 32'hFFFF_FFFF;
        bus.B        = 32'hFFFF_FFFF;
        bus.Cin      = ~c;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.S !== 32'h0) $display("FAIL reset_S got %h want 00000000", bus.S); else pass_cnt++;
        total_cnt++; if (bus.Cout !== 1'b0) $display("FAIL reset_Cout got %b want 0", bus.Cout); else pass_cnt++;
        total_cnt++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else pass_cnt++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        do_op(32'h12345678, 32'h87654321, 1'b0, lat);
        total_cnt++; if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (bus.S !== 32'h99999999) $display("FAIL basic_S got %h want 99999999", bus.S); else pass_cnt++;
        total_cnt++; if (bus.Cout !== 1'b0) $display("FAIL basic_Cout got %b want 0", bus.Cout); else pass_cnt++;
        total_cnt++; if (bus.err !== 1'b0) $display("FAIL basic_err got %b want 0", bus.err); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL basic_busy got %b want 1", bus.busy); else pass_cnt++;
        release_result();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drop_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL basic_idle_ready got %b want 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_carry_ripple();
        int lat;
        do_op(32'h99999999, 32'h00000001, 1'b0, lat);
        total_cnt++; if (lat !== 4) $display("FAIL ripple1_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (bus.S !== 32'h00000000) $display("FAIL ripple1_S got %h want 00000000", bus.S); else pass_cnt++;
        total_cnt++; if (bus.Cout !== 1'b1) $display("FAIL ripple1_Cout got %b want 1", bus.Cout); else pass_cnt++;
        release_result();
        do_op(32'h49999999, 32'h50000000, 1'b1, lat);
        total_cnt++; if (bus.S !== 32'h00000000) $display("FAIL ripple2_S got %h want 00000000", bus.S); else pass_cnt++;
        total_cnt++; if (bus.Cout !== 1'b1) $display("FAIL ripple2_Cout got %b want 1", bus.Cout); else pass_cnt++;
        release_result();
        do_op(32'h00000099, 32'h00000001, 1'b1, lat);
        total_cnt++; if (bus.S !== 32'h00000101) $display("FAIL ripple3_S got %h want 00000101", bus.S); else pass_cnt++;
        total_cnt++; if (bus.Cout !== 1'b0) $display("FAIL ripple3_Cout got %b want 0", bus.Cout); else pass_cnt++;
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(32'h11111111, 32'h22222222, 1'b0, lat);
        bus.A        = 32'h00000001;
        bus.B        = 32'h00000002;
        bus.Cin      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b want 1", i, bus.out_valid); else pass_cnt++;
            total_cnt++; if (bus.S !== 32'h33333333) $display("FAIL bp_hold_S[%0d] got %h want 33333333", i, bus.S); else pass_cnt++;
            total_cnt++; if (bus.Cout !== 1'b0) $display("FAIL bp_hold_Cout[%0d] got %b want 0", i, bus.Cout); else pass_cnt++;
            total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); else pass_cnt++;
        end
        bus.in_valid = 1'b0;
        release_result();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", bus.in_ready); else pass_cnt++;
        do_op(32'h00000001, 32'h00000002, 1'b0, lat);
        total_cnt++; if (lat !== 4) $display("FAIL bp_next_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (bus.S !== 32'h00000003) $display("FAIL bp_next_S got %h want 00000003", bus.S); else pass_cnt++;
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bus.A        = 32'h12345678;
        bus.B        = 32'h11111111;
        bus.Cin      = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        total_cnt++; if (bus.S !== 32'h00000089) $display("FAIL midrun_partial_S got %h want 00000089", bus.S); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL midrun_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.S !== 32'h0) $display("FAIL midrun_S got %h want 00000000", bus.S); else pass_cnt++;
        total_cnt++; if (bus.Cout !== 1'b0) $display("FAIL midrun_Cout got %b want 0", bus.Cout); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL midrun_busy got %b want 0", bus.busy); else pass_cnt++;
        step();
        reset = 1'b0;
        step();
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL midrun_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        do_op(32'h00000005, 32'h00000005, 1'b0, lat);
        total_cnt++; if (lat !== 4) $display("FAIL midrun_fresh_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (bus.S !== 32'h00000010) $display("FAIL midrun_fresh_S got %h want 00000010", bus.S); else pass_cnt++;
        release_result();
    endtask

    task automatic test_err();
        int lat;
        do_op(32'h0000000A, 32'h00000001, 1'b0, lat);
        total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL err_valid got %b want 1", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.err !== 1'b1) $display("FAIL err_flag got %b want 1", bus.err); else pass_cnt++;
        release_result();
        do_op(32'h00000003, 32'h00000004, 1'b0, lat);
        total_cnt++; if (bus.err !== 1'b0) $display("FAIL err_clear got %b want 0", bus.err); else pass_cnt++;
        total_cnt++; if (bus.S !== 32'h00000007) $display("FAIL err_clear_S got %h want 00000007", bus.S); else pass_cnt++;
        release_result();
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_err();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_seq_adder_ctrl.md
Name: bcd_seq_adder_ctrl

Overview:
- Sequencing controller for multi-digit packed-BCD addition; reuses one 2-digit (8-bit) BCD adder slice across NDIG/2 cycles, least-significant digit pair first.
- Sits between an operand producer and a result consumer; valid/ready handshake on both sides.
- Trades latency for area against a fully parallel NDIG-digit adder.

Parameters:
- NDIG, 8, number of BCD digits per operand; even, >= 2; operand width 4*NDIG bits.

Ports:
- clk        in   1       rising-edge clock
- reset      in   1       asynchronous, active-high reset
- in_valid   in   1       operands A, B, Cin valid
- in_ready   out  1       controller accepts operands (IDLE only)
- A          in   4*NDIG  packed BCD operand, digit 0 in [3:0]
- B          in   4*NDIG  packed BCD operand
- Cin        in   1       carry into digit 0
- out_valid  out  1       S/Cout/err valid
- out_ready  in   1       consumer accepts result
- S          out  4*NDIG  packed BCD sum
- Cout       out  1       carry out of digit NDIG-1
- err        out  1       at least one input digit was > 9
- busy       out  1       high in RUN or DONE

Behaviour:
- Reset (async, active-high): state=IDLE; S=0, Cout=0, err=0, out_valid=0, busy=0, pair index=0, carry=0. Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A, B; carry<=Cin; idx<=0; S<=0; Cout<=0.
  - err<=OR over all 2*NDIG input nibbles of (nibble>9).
  - Go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, apply slice to digit pair idx (bits [8*idx+7:8*idx]) with carry.
  - Write the slice sum into S at the same position; carry<=slice carry-out; idx<=idx+1.
  - When idx==NDIG/2-1: Cout<=slice carry-out; go to DONE.
- DONE:
  - out_valid=1; S, Cout, err held stable.
  - On out_ready: go to IDLE. out_valid drops in the following cycle.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency: accept edge k -> out_valid high after edge k+NDIG/2 (4 cycles for NDIG=8). Throughput: one operation per NDIG/2+2 cycles with out_ready held high.
- Digit arithmetic (per digit): t = a + b + c as a 5-bit binary sum (max 19).
  - If t > 9: digit = (t+6)[3:0], carry = 1.
  - Otherwise: digit = t[3:0], carry = 0.
  - Digit-0 carry feeds digit 1 inside the slice.
- Invalid digits (>9): err asserted; arithmetic still runs by the same rule; S is unspecified but deterministic.
- in_valid is ignored outside IDLE. A, B and Cin may change after acceptance without affecting the result.
- busy = (state != IDLE).

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0])
  - constants BCD_MAX=9, BCD_CORR=6
  - enum ctrl_state_t {IDLE, RUN, DONE}
  - function bcd_digit_invalid()
- Sub-module bcd2_slice (combinational): inputs a[7:0], b[7:0], cin; outputs s[7:0], cout. Implements the digit rule above twice in ripple.
- The controller instantiates exactly one bcd2_slice; a[7:0] and b[7:0] come from the latched operand through an idx-indexed mux.

Test Plan (NDIG=8):
- A=12345678, B=87654321, Cin=0 -> S=99999999, Cout=0, err=0; out_valid exactly 4 cycles after accept.
- A=99999999, B=00000001, Cin=0 -> S=00000000, Cout=1 (carry ripples through all 4 pair cycles).
- A=49999999, B=50000000, Cin=1 -> S=00000000, Cout=1; separately A=00000099, B=00000001, Cin=1 -> S=00000101, Cout=0.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> S/Cout held stable, in_ready=0, a new in_valid ignored. Then out_ready=1 -> IDLE next cycle; the next operand is accepted.
- Reset asserted in 2nd RUN cycle -> out_valid, S, Cout, busy immediately 0; after release in_ready=1; a fresh 00000005+00000005 gives S=00000010.
- A=0000000A, B=00000001 -> err=1 with out_valid. Then 00000003+00000004 -> err=0, S=00000007.
